// File: rtl/stream_out.sv
// Block serializer: accepts 128-bit tagged blocks into a 2-entry FIFO and emits them as 8 x 16-bit words, MSB first.
// Optional sticky overflow flag on dropped blocks: define STREAM_OUT_OVF_EN.
module stream_out (
    input  logic         clk,
    input  logic         rst,
    input  logic         vin,
    input  logic [1:0]   tin,
    input  logic [127:0] din,
    output logic         rdy,
    output logic         vout,
    output logic [1:0]   tout,
    output logic [15:0]  dout
`ifdef STREAM_OUT_OVF_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     occ_q, occ_d;
    logic [127:0]   f0_data_q, f0_data_d;
    logic [127:0]   f1_data_q, f1_data_d;
    logic [1:0]     f0_tag_q, f0_tag_d;
    logic [1:0]     f1_tag_q, f1_tag_d;
    logic [127:0]   sr_q, sr_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           vout_q, vout_d;
    logic [1:0]     tout_q, tout_d;
    logic [15:0]    dout_q, dout_d;

    logic           accept;
    logic           load_slot;
    logic           load;
    logic           pop;
    logic           push;
    logic           wr_first;
    logic [127:0]   src_data;
    logic [1:0]     src_tag;

    // rdy depends only on registered occupancy, never on vin
    assign rdy       = (occ_q < 2'd2);
    assign accept    = vin && rdy;
    assign load_slot = (state_q == IDLE) || (cnt_q == 3'd7);
    assign load      = load_slot && ((occ_q != 2'd0) || accept);
    assign pop       = load && (occ_q != 2'd0);
    // a block loaded straight from the input (bypass) never enters the FIFO
    assign push      = accept && !(load && (occ_q == 2'd0));
    assign wr_first  = (occ_q == 2'd0) || ((occ_q == 2'd1) && pop);
    assign src_data  = (occ_q != 2'd0) ? f0_data_q : din;
    assign src_tag   = (occ_q != 2'd0) ? f0_tag_q  : tin;

    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        f0_data_d = f0_data_q;
        f1_data_d = f1_data_q;
        f0_tag_d  = f0_tag_q;
        f1_tag_d  = f1_tag_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        vout_d    = vout_q;
        tout_d    = tout_q;
        dout_d    = dout_q;

        if (load) begin
            sr_d    = {src_data[111:0], 16'h0000};
            dout_d  = src_data[127:112];
            tout_d  = src_tag;
            vout_d  = 1'b1;
            cnt_d   = 3'd0;
            state_d = SEND;
        end else if ((state_q == SEND) && (cnt_q != 3'd7)) begin
            dout_d  = sr_q[127:112];
            sr_d    = {sr_q[111:0], 16'h0000};
            cnt_d   = cnt_q + 3'd1;
        end else if (state_q == SEND) begin
            vout_d  = 1'b0;
            cnt_d   = 3'd0;
            state_d = IDLE;
        end

        if (pop) begin
            f0_data_d = f1_data_q;
            f0_tag_d  = f1_tag_q;
        end
        if (push) begin
            if (wr_first) begin
                f0_data_d = din;
                f0_tag_d  = tin;
            end else begin
                f1_data_d = din;
                f1_tag_d  = tin;
            end
        end

        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            occ_q     <= 2'd0;
            f0_data_q <= '0;
            f1_data_q <= '0;
            f0_tag_q  <= 2'b00;
            f1_tag_q  <= 2'b00;
            sr_q      <= '0;
            cnt_q     <= 3'd0;
            vout_q    <= 1'b0;
            tout_q    <= 2'b00;
            dout_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            f0_data_q <= f0_data_d;
            f1_data_q <= f1_data_d;
            f0_tag_q  <= f0_tag_d;
            f1_tag_q  <= f1_tag_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            vout_q    <= vout_d;
            tout_q    <= tout_d;
            dout_q    <= dout_d;
        end
    end

    assign vout = vout_q;
    assign tout = tout_q;
    assign dout = dout_q;

`ifdef STREAM_OUT_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (vin && !rdy) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
